// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and helpers for the pipelined adder.
// Opcode encodings, default geometry and slice-geometry helpers.
package alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;

  function automatic int slice_w(
    input int w,
    input int s
  );
    return w / s;
  endfunction

  function automatic bit geom_ok(
    input int w,
    input int s
  );
    return (s >= 1) && (s <= w) && (w % s == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// adder_slice: one registered SW-bit add step of the pipelined adder.
// Carries the operands and partial result alongside the slice carry.
module adder_slice
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SW    = 8,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] bp,
  input  logic [WIDTH-1:0] res,
  input  logic             carry,
  output logic             valid,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] bp_q,
  output logic [WIDTH-1:0] res_q,
  output logic             carry_q
);

  localparam int LO = IDX * SW;

  logic [SW:0]      part;
  logic [WIDTH-1:0] res_next;

  always_comb begin
    part = {1'b0, a[LO +: SW]}
         + {1'b0, bp[LO +: SW]}
         + {{SW{1'b0}}, carry};
    res_next = res;
    res_next[LO +: SW] = part[SW-1:0];
  end

  // Data only moves with a valid token so held outputs never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      a_q     <= '0;
      bp_q    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
    end else if (load) begin
      valid <= valid_in;
      if (valid_in) begin
        a_q     <= a;
        bp_q    <= bp;
        res_q   <= res_next;
        carry_q <= part[SW];
      end
    end
  end

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep carry-chained add/sub with elastic
// valid/ready flow control and carry, overflow and zero flags.
module pipelined_adder
  import alu_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SW = slice_w(WIDTH, STAGES);

  if (!geom_ok(WIDTH, STAGES)) begin : g_bad_geom
    $error("pipelined_adder: WIDTH must be a multiple of STAGES");
  end

  logic [WIDTH-1:0] a_p   [STAGES+1];
  logic [WIDTH-1:0] bp_p  [STAGES+1];
  logic [WIDTH-1:0] res_p [STAGES+1];
  logic [STAGES:0]  carry_p;
  logic [STAGES:0]  vld;
  logic [STAGES:0]  ld;

  assign a_p[0]     = a;
  assign bp_p[0]    = (sub == OP_SUB) ? ~b : b;
  assign res_p[0]   = '0;
  assign carry_p[0] = (sub == OP_ADD) ? cin : 1'b1;
  assign vld[0]     = in_valid;
  assign ld[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // A stage moves when empty or when its successor moves.
    assign ld[k] = !vld[k+1] | ld[k+1];

    adder_slice #(
      .WIDTH (WIDTH),
      .SW    (SW),
      .IDX   (k)
    ) u_slice (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (ld[k]),
      .valid_in (vld[k]),
      .a        (a_p[k]),
      .bp       (bp_p[k]),
      .res      (res_p[k]),
      .carry    (carry_p[k]),
      .valid    (vld[k+1]),
      .a_q      (a_p[k+1]),
      .bp_q     (bp_p[k+1]),
      .res_q    (res_p[k+1]),
      .carry_q  (carry_p[k+1])
    );
  end

  logic a_msb;
  logic bp_msb;

  assign a_msb     = a_p[STAGES][WIDTH-1];
  assign bp_msb    = bp_p[STAGES][WIDTH-1];
  assign in_ready  = ld[0];
  assign out_valid = vld[STAGES];
  assign sum       = res_p[STAGES];
  assign cout      = carry_p[STAGES];
  assign ovf       = (a_msb == bp_msb)
                   & (sum[WIDTH-1] != a_msb);
  assign zero      = out_valid & ~|sum;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed vector table plus streaming, stall,
// reset and geometry-sweep sequences for pipelined_adder.
module tb_pipelined_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_adder #(
    .WIDTH  (32),
    .STAGES (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  localparam int NSW = 5;
  localparam int CW [NSW] = '{32, 32, 32, 32, 16};
  localparam int CS [NSW] = '{1, 2, 8, 32, 4};

  logic           sw_valid;
  logic [NSW-1:0] sw_ready;
  logic [NSW-1:0] sw_ovalid;
  logic [NSW-1:0] sw_cout;
  logic [NSW-1:0] sw_ovf;
  logic [NSW-1:0] sw_zero;
  logic [31:0]    sw_sum [NSW];

  for (genvar i = 0; i < NSW; i++) begin : g_sw
    logic [CW[i]-1:0] s;
    pipelined_adder #(
      .WIDTH  (CW[i]),
      .STAGES (CS[i])
    ) u_sw (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (sw_valid),
      .in_ready  (sw_ready[i]),
      .a         (a[CW[i]-1:0]),
      .b         (b[CW[i]-1:0]),
      .sub       (sub),
      .cin       (cin),
      .out_valid (sw_ovalid[i]),
      .out_ready (1'b1),
      .sum       (s),
      .cout      (sw_cout[i]),
      .ovf       (sw_ovf[i]),
      .zero      (sw_zero[i])
    );
    assign sw_sum[i] = 32'(s);
  end

  task automatic chk(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Returns {ovf, cout, sum[31:0]}.
  function automatic logic [33:0] model(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic        s,
    input logic        c
  );
    logic [31:0] yp;
    logic [32:0] r;
    logic        ov;
    yp = s ? ~y : y;
    r  = {1'b0, x} + {1'b0, yp}
       + {32'd0, (s ? 1'b1 : c)};
    ov = (x[31] == yp[31]) && (r[31] != x[31]);
    return {ov, r};
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic [31:0] s;
    logic        c;
    logic        o;
    logic        z;
  } vec_t;

  vec_t vt [11];

  task automatic run_one(input vec_t v, input int idx);
    int lat;
    bit got;
    @(negedge clk);
    a = v.a;
    b = v.b;
    sub = v.sub;
    cin = v.cin;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    chk($sformatf("v%0d in_ready", idx), in_ready, 1);
    lat = 0;
    got = 0;
    while (!got && lat < 20) begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
      if (out_valid) got = 1;
    end
    chk($sformatf("v%0d latency", idx), lat, 4);
    chk($sformatf("v%0d sum", idx), sum, v.s);
    chk($sformatf("v%0d cout", idx), cout, v.c);
    chk($sformatf("v%0d ovf", idx), ovf, v.o);
    chk($sformatf("v%0d zero", idx), zero, v.z);
  endtask

  logic [33:0] expq [$];
  int n_rx;
  int ready_low;
  int first_rx;
  int last_rx;
  int acc_mark;

  task automatic stream(
    input int    n,
    input int    st_from,
    input int    st_to,
    input string tag
  );
    int          sent;
    bit          held;
    logic [35:0] hold_v;
    logic [33:0] e;
    sent = 0;
    held = 0;
    hold_v = '0;
    n_rx = 0;
    ready_low = 0;
    first_rx = -1;
    last_rx = -1;
    acc_mark = -1;
    expq.delete();
    for (int cyc = 0; cyc < 400 && n_rx < n; cyc++) begin
      @(negedge clk);
      if (held)
        chk({tag, " hold"},
            {out_valid, cout, ovf, zero, sum}, hold_v);
      out_ready = !(cyc >= st_from && cyc < st_to);
      if (st_to > st_from && cyc == st_to)
        acc_mark = sent;
      if (sent < n) begin
        in_valid = 1'b1;
        a = $urandom;
        b = $urandom;
        sub = 1'($urandom_range(0, 1));
        cin = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid) begin
        if (in_ready) begin
          expq.push_back(model(a, b, sub, cin));
          sent++;
        end else begin
          ready_low++;
        end
      end
      held = out_valid && !out_ready;
      hold_v = {out_valid, cout, ovf, zero, sum};
      if (out_valid && out_ready) begin
        chk({tag, " result pending"}, expq.size() > 0, 1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk({tag, " result"},
              {cout, ovf, zero, sum},
              {e[32], e[33], (e[31:0] == 32'd0), e[31:0]});
        end
        n_rx++;
        if (first_rx < 0) first_rx = cyc;
        last_rx = cyc;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic run_sweep(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic        c,
    input logic [31:0] es32,
    input logic        ec32,
    input logic [31:0] es16,
    input logic        ec16
  );
    int lat [NSW];
    @(negedge clk);
    a = x;
    b = y;
    sub = 1'b0;
    cin = c;
    sw_valid = 1'b1;
    #1;
    chk("sweep in_ready", sw_ready, {NSW{1'b1}});
    for (int i = 0; i < NSW; i++) lat[i] = -1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      sw_valid = 1'b0;
      for (int i = 0; i < NSW; i++) begin
        if (sw_ovalid[i] && lat[i] < 0) begin
          lat[i] = cyc;
          chk($sformatf("sweep%0d sum", i), sw_sum[i],
              (CW[i] == 16) ? es16 : es32);
          chk($sformatf("sweep%0d cout", i), sw_cout[i],
              (CW[i] == 16) ? ec16 : ec32);
        end
      end
    end
    for (int i = 0; i < NSW; i++)
      chk($sformatf("sweep%0d latency", i), lat[i], CS[i]);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0;
    in_valid = 1'b0;
    sw_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    sub = 1'b0;
    cin = 1'b0;

    vt[0]  = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0,
               32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vt[1]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
               32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vt[2]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0,
               32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vt[3]  = '{32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0,
               32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vt[4]  = '{32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0,
               32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{32'h0000_FFFF, 32'h0000_0000, 1'b0, 1'b1,
               32'h0001_0000, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1,
               32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0,
               32'h0000_0000, 1'b1, 1'b1, 1'b1};
    vt[8]  = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0,
               32'hACF1_3568, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1,
               32'h0000_0007, 1'b1, 1'b0, 1'b0};
    vt[10] = '{32'h00FF_00FF, 32'h00FF_0001, 1'b0, 1'b0,
               32'h01FE_0100, 1'b0, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset outputs",
        {out_valid, cout, ovf, zero, sum}, 36'd0);
    chk("reset sweep valid", sw_ovalid, '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready after reset", in_ready, 1);

    foreach (vt[i]) run_one(vt[i], i);

    stream(100, 0, 0, "stream");
    chk("stream count", n_rx, 100);
    chk("stream ready low", ready_low, 0);
    chk("stream first", first_rx, 4);
    chk("stream spacing", last_rx - first_rx, 99);
    chk("stream leftover", expq.size(), 0);

    stream(8, 0, 14, "stall");
    chk("stall accepts", acc_mark, 4);
    chk("stall ready low", ready_low, 10);
    chk("stall count", n_rx, 8);
    chk("stall leftover", expq.size(), 0);

    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = 32'h100 + 32'(i);
      b = 32'h1;
      sub = 1'b0;
      cin = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("pre-reset valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset valid", out_valid, 0);
    chk("async reset sum", sum, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("ready after rst rise", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("stale after reset", seen, 0);

    run_sweep(32'h0000_FFFF, 32'h0, 1'b1,
              32'h0001_0000, 1'b0, 32'h0, 1'b1);
    run_sweep(32'hFFFF_FFFF, 32'h0, 1'b1,
              32'h0, 1'b1, 32'h0, 1'b1);
    run_sweep(32'h0000_0001, 32'hFFFF_FFFF, 1'b0,
              32'h0, 1'b1, 32'h0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
